// File: rtl/dmem_obi_slave.sv
// Word-addressed data RAM serving the LSU over req/gnt/rvalid, with programmable
// grant and response latencies. One outstanding transaction at a time.
module dmem_obi_slave #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned GNT_LAT     = 0,
  parameter int unsigned RVALID_LAT  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              data_req_i,
  input  logic [ADDR_W-1:0] data_addr_i,
  input  logic              data_we_i,
  input  logic [3:0]        data_be_i,
  input  logic [31:0]       data_wdata_i,
  output logic              data_gnt_o,
  output logic              data_rvalid_o,
  output logic [31:0]       data_rdata_o,
  output logic              data_err_o
);

  localparam int unsigned IdxW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  if (GNT_LAT > 15) begin : g_bad_gnt_lat
    $error("GNT_LAT must be 0..15");
  end
  if (RVALID_LAT < 1 || RVALID_LAT > 15) begin : g_bad_rvalid_lat
    $error("RVALID_LAT must be 1..15");
  end
  if (DEPTH_WORDS < 1 || ADDR_W < IdxW || ADDR_W > 64) begin : g_bad_geometry
    $error("DEPTH_WORDS/ADDR_W combination unsupported");
  end

  typedef enum logic [1:0] {StIdle, StWaitGnt, StWaitRsp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  rsp_cnt_q, rsp_cnt_d;
  logic        rvalid_q, rvalid_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic        cap_we_q, cap_we_d;
  logic        cap_oor_q, cap_oor_d;
  logic [31:0] cap_word_q, cap_word_d;
  logic        gnt;

  logic [31:0]     mem [DEPTH_WORDS];
  logic            in_range;
  logic [IdxW-1:0] idx;
  logic [31:0]     mem_word;

  assign in_range = 64'(data_addr_i) < 64'(DEPTH_WORDS);
  assign idx      = data_addr_i[IdxW-1:0];
  assign mem_word = in_range ? mem[idx] : '0;

  // With RVALID_LAT=1 the rvalid cycle is entered straight from the grant, so the
  // FSM is already idle then and can grant back-to-back.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rsp_cnt_d = rsp_cnt_q;
    gnt       = 1'b0;
    rvalid_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (data_req_i) begin
          if (GNT_LAT == 0) begin
            gnt = 1'b1;
          end else begin
            cnt_d   = 4'd1;
            state_d = StWaitGnt;
          end
        end
      end
      StWaitGnt: begin
        if (!data_req_i) begin
          state_d = StIdle;
        end else if (cnt_q == 4'(GNT_LAT)) begin
          gnt = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StWaitRsp: begin
        if (rsp_cnt_q == 4'(RVALID_LAT - 1)) begin
          rvalid_d = 1'b1;
          state_d  = StIdle;
        end else begin
          rsp_cnt_d = rsp_cnt_q + 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (gnt) begin
      if (RVALID_LAT == 1) begin
        rvalid_d = 1'b1;
        state_d  = StIdle;
      end else begin
        rsp_cnt_d = 4'd1;
        state_d   = StWaitRsp;
      end
    end
  end

  assign cap_we_d   = gnt ? data_we_i : cap_we_q;
  assign cap_oor_d  = gnt ? !in_range : cap_oor_q;
  assign cap_word_d = gnt ? mem_word  : cap_word_q;

  always_comb begin
    err_d   = 1'b0;
    rdata_d = rdata_q;
    if (rvalid_d) begin
      err_d = cap_oor_d;
      if (cap_oor_d) begin
        rdata_d = '0;
      end else if (!cap_we_d) begin
        rdata_d = cap_word_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      rsp_cnt_q  <= '0;
      rvalid_q   <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      cap_we_q   <= 1'b0;
      cap_oor_q  <= 1'b0;
      cap_word_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rsp_cnt_q  <= rsp_cnt_d;
      rvalid_q   <= rvalid_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      cap_we_q   <= cap_we_d;
      cap_oor_q  <= cap_oor_d;
      cap_word_q <= cap_word_d;
    end
  end

  // RAM array is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (gnt && data_we_i && in_range) begin
      for (int n = 0; n < 4; n++) begin
        if (data_be_i[n]) begin
          mem[idx][8*n +: 8] <= data_wdata_i[8*n +: 8];
        end
      end
    end
  end

  assign data_gnt_o    = gnt;
  assign data_rvalid_o = rvalid_q;
  assign data_rdata_o  = rdata_q;
  assign data_err_o    = err_q;

endmodule
